// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - state encodings and BCD constants shared by the stopwatch slice
package stopwatch_ctrl_pkg;
  localparam logic [1:0] SW_IDLE = 2'd0;
  localparam logic [1:0] SW_RUN  = 2'd1;
  localparam logic [1:0] SW_STOP = 2'd2;
  localparam logic [1:0] SW_OVF  = 2'd3;

  localparam int BCD_W = 4;
  localparam logic [4*BCD_W-1:0] SW_MAX_BCD = 16'h9999;
endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_cnt.sv
// rtl/stopwatch_ctrl_bcd_digit_cnt.sv - one BCD digit (0..9) with ripple carry-out
module bcd_digit_cnt
  import stopwatch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);
  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (inc_i) begin
      digit_d = (digit_q == 4'd9) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  assign carry_o = inc_i && (digit_q == 4'd9);
endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/stop stopwatch FSM with prescaler and BCD SS.cc count
// Optional lap-hold display freeze is built when SW_LAP_HOLD_EN is defined.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_en,
  input  logic        start_stop_p,
  input  logic        clear_p,
  input  logic        lap_p,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        overflow,
  output logic        lap_active
);
  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] count;
  logic [3:0]  carry;
  logic        cnt_en, wrap, all_nines, inc, to_idle;

  always_comb begin
    cnt_en    = (state_q == SW_RUN) && tick_en;
    wrap      = cnt_en && (presc_q == PRESC_MAX);
    all_nines = (count == SW_MAX_BCD);
    inc       = wrap && !all_nines;
    state_d   = state_q;
    to_idle   = 1'b0;
    case (state_q)
      SW_IDLE: if (!clear_p && start_stop_p) state_d = SW_RUN;
      // start_stop beats clear here; the increment that would pass 99.99 saturates instead
      SW_RUN: begin
        if (start_stop_p)          state_d = SW_STOP;
        else if (wrap && all_nines) state_d = SW_OVF;
      end
      SW_STOP: begin
        if (clear_p) begin
          state_d = SW_IDLE;
          to_idle = 1'b1;
        end else if (start_stop_p) begin
          state_d = SW_RUN;
        end
      end
      default: begin
        if (clear_p) begin
          state_d = SW_IDLE;
          to_idle = 1'b1;
        end
      end
    endcase

    presc_d = presc_q;
    if (to_idle || wrap) presc_d = '0;
    else if (cnt_en)     presc_d = presc_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SW_IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Digit 0 is c1, digit 3 is s10; each digit's carry feeds the next one up.
  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_cnt u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   ((i == 0) ? inc : carry[(i == 0) ? 0 : i-1]),
      .clr_i   (to_idle),
      .digit_o (count[BCD_W*i +: BCD_W]),
      .carry_o (carry[i])
    );
  end

  assign running  = (state_q == SW_RUN);
  assign overflow = (state_q == SW_OVF);

`ifdef SW_LAP_HOLD_EN
  logic        hold_q, hold_d;
  logic [15:0] lap_q, lap_d;

  always_comb begin
    hold_d = hold_q;
    lap_d  = lap_q;
    if (to_idle) begin
      hold_d = 1'b0;
    end else if (lap_p && (state_q == SW_RUN || state_q == SW_STOP)) begin
      hold_d = !hold_q;
      if (!hold_q) lap_d = count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      lap_q  <= '0;
    end else begin
      hold_q <= hold_d;
      lap_q  <= lap_d;
    end
  end

  assign disp_bcd   = hold_q ? lap_q : count;
  assign lap_active = hold_q;
`else
  logic unused_lap;
  assign unused_lap = lap_p;
  assign disp_bcd   = count;
  assign lap_active = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed bench with per-cycle reference model for stopwatch_ctrl
module tb_stopwatch_ctrl;
  localparam int TD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_OVF = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_en = 1'b0, start_stop_p = 1'b0, clear_p = 1'b0, lap_p = 1'b0;
  logic [15:0] disp_bcd;
  logic        running, overflow, lap_active;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_en      (tick_en),
    .start_stop_p (start_stop_p),
    .clear_p      (clear_p),
    .lap_p        (lap_p),
    .disp_bcd     (disp_bcd),
    .running      (running),
    .overflow     (overflow),
    .lap_active   (lap_active)
  );

  always #5 clk = ~clk;

`ifdef SW_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  // Reference: elapsed hundredths as a plain integer, converted to digits only for display.
  int m_mode, m_cnt, m_presc, m_lap;
  bit m_hold;

  always @(posedge clk or negedge rst_n) begin
    int md, c, p, l;
    bit h, sat;
    if (!rst_n) begin
      m_mode <= M_IDLE; m_cnt <= 0; m_presc <= 0; m_hold <= 0; m_lap <= 0;
    end else begin
      md = m_mode; c = m_cnt; p = m_presc; h = m_hold; l = m_lap; sat = 0;
      if (LAP_EN && lap_p && (m_mode == M_RUN || m_mode == M_STOP)) begin
        if (!m_hold) l = m_cnt;
        h = !m_hold;
      end
      if (m_mode == M_RUN && tick_en) begin
        if (p == TD - 1) begin
          p = 0;
          if (c == 9999) sat = 1; else c = c + 1;
        end else p = p + 1;
      end
      case (m_mode)
        M_IDLE: if (!clear_p && start_stop_p) md = M_RUN;
        M_RUN:  if (start_stop_p) md = M_STOP; else if (sat) md = M_OVF;
        M_STOP: if (clear_p) md = M_IDLE; else if (start_stop_p) md = M_RUN;
        default: if (clear_p) md = M_IDLE;
      endcase
      if (md == M_IDLE) begin c = 0; p = 0; h = 0; end
      m_mode <= md; m_cnt <= c; m_presc <= p; m_hold <= h; m_lap <= l;
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_disp", disp_bcd, to_bcd(m_hold ? m_lap : m_cnt));
    check("model_running", running, m_mode == M_RUN);
    check("model_overflow", overflow, m_mode == M_OVF);
    check("model_lap_active", lap_active, m_hold);
  end

  task automatic drive(input logic ss, input logic clr, input logic lp, input logic tk);
    @(negedge clk);
    start_stop_p = ss; clear_p = clr; lap_p = lp; tick_en = tk;
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_disp", disp_bcd, 16'h0000);
    check("reset_flags", {running, overflow, lap_active}, 3'b000);
    rst_n = 1'b1;

    // IDLE: clear wins over simultaneous start_stop
    drive(1, 1, 0, 0); drive(0, 0, 0, 0);
    check("idle_clear_wins", running, 1'b0);

    // 1: start, 20 ticks at TICK_DIV=2
    drive(1, 0, 0, 0); ticks(20);
    check("t1_disp", disp_bcd, 16'h0010);
    check("t1_running", running, 1'b1);

    // 2: run to 50, pause holds count, resume
    ticks(80);
    check("t2_run50", disp_bcd, 16'h0050);
    drive(1, 0, 0, 0); ticks(10);
    check("t2_paused", disp_bcd, 16'h0050);
    check("t2_stopped", running, 1'b0);
    drive(1, 0, 0, 0); ticks(2);
    check("t2_resumed", disp_bcd, 16'h0051);

    // 4: start_stop wins over clear in RUN
    drive(1, 1, 0, 0); drive(0, 0, 0, 0);
    check("t4_stop_not_clear", {running, disp_bcd}, {1'b0, 16'h0051});
    drive(0, 1, 0, 0); drive(0, 0, 0, 0);
    check("t4_cleared", disp_bcd, 16'h0000);

    // 5: lap hold (ignored in default build)
    drive(1, 0, 0, 0); ticks(246);
    check("t5_at0123", disp_bcd, 16'h0123);
    drive(0, 0, 1, 0); ticks(20);
    check("t5_lap_active", lap_active, LAP_EN);
    check("t5_disp_held", disp_bcd, LAP_EN ? 16'h0123 : 16'h0133);
    drive(0, 0, 1, 0); drive(0, 0, 0, 0);
    check("t5_released", {lap_active, disp_bcd}, {1'b0, 16'h0133});
    drive(1, 0, 0, 0); drive(0, 1, 0, 0); drive(0, 0, 0, 0);
    check("t5_cleared", disp_bcd, 16'h0000);

    // 3: run to 99.98, then saturate
    drive(1, 0, 0, 0); ticks(19996);
    check("t3_9998", disp_bcd, 16'h9998);
    ticks(4);
    check("t3_9999", disp_bcd, 16'h9999);
    check("t3_ovf_flags", {running, overflow}, 2'b01);
    drive(1, 0, 0, 0); ticks(4);
    check("t3_ss_ignored", {overflow, disp_bcd}, {1'b1, 16'h9999});
    drive(0, 1, 0, 0); drive(0, 0, 0, 0);
    check("t3_clear", {running, overflow, disp_bcd}, {2'b00, 16'h0000});

    // 6: async reset mid-run
    drive(1, 0, 0, 0); repeat (84) drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    check("t6_at0042", disp_bcd, 16'h0042);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    check("t6_async_disp", disp_bcd, 16'h0000);
    check("t6_async_flags", {running, overflow, lap_active}, 3'b000);
    drive(0, 0, 0, 0); rst_n = 1'b1; drive(0, 0, 0, 0);
    check("t6_after_release", {running, disp_bcd}, {1'b0, 16'h0000});
    drive(1, 0, 0, 0); ticks(2);
    check("t6_restart", disp_bcd, 16'h0001);

    drive(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
